// File: rtl/gesture_classify_ctrl.sv
// Sequencer around an external gesture classifier: latches features, waits out the classifier
// latency, debounces result codes (when GESTURE_CTRL_DEBOUNCE_EN is defined) and hands reports out.
module gesture_classify_ctrl #(
  parameter int unsigned LATENCY       = 8,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_done,
  input  logic [31:0] Hu_1,
  input  logic [31:0] Hu_2,
  input  logic [23:0] Perimeter_Aera,
  output logic [31:0] cls_hu_1,
  output logic [31:0] cls_hu_2,
  output logic [23:0] cls_pa,
  input  logic [5:0]  cls_sdata,
  output logic [5:0]  out_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(LATENCY - 1);

  state_t      state_q;
  logic [31:0] cls_hu_1_q;
  logic [31:0] cls_hu_2_q;
  logic [23:0] cls_pa_q;
  logic [7:0]  wait_cnt_q;
  logic [5:0]  sample_q;
  logic [5:0]  out_code_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [7:0]  drop_cnt_q;
  logic        report_s;

`ifdef GESTURE_CTRL_DEBOUNCE_EN
  localparam logic [3:0] STABLE_TGT = 4'(STABLE_FRAMES);

  logic [5:0] last_code_q;
  logic [5:0] last_rep_q;
  logic [3:0] stable_cnt_q;
  logic [3:0] stable_cnt_d;

  // Run length of the freshly sampled code and whether it earns a new report.
  always_comb begin
    stable_cnt_d = 4'd1;
    if (sample_q == last_code_q) begin
      if (stable_cnt_q == 4'd15) begin
        stable_cnt_d = 4'd15;
      end else begin
        stable_cnt_d = stable_cnt_q + 4'd1;
      end
    end else begin
      stable_cnt_d = 4'd1;
    end
    report_s = (stable_cnt_d == STABLE_TGT) && (sample_q != last_rep_q);
  end
`else
  // Without debouncing every classified frame is reported.
  always_comb begin
    report_s = 1'b1;
  end
`endif

  // Frame sequencer, operand latches, drop counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cls_hu_1_q  <= 32'd0;
      cls_hu_2_q  <= 32'd0;
      cls_pa_q    <= 24'd0;
      wait_cnt_q  <= 8'd0;
      sample_q    <= 6'd0;
      out_code_q  <= 6'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_cnt_q  <= 8'd0;
`ifdef GESTURE_CTRL_DEBOUNCE_EN
      last_code_q  <= 6'h3F;
      last_rep_q   <= 6'h3F;
      stable_cnt_q <= 4'd0;
`endif
    end else begin
      if (frame_done && (state_q != ST_IDLE) && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_done) begin
            cls_hu_1_q <= Hu_1;
            cls_hu_2_q <= Hu_2;
            cls_pa_q   <= Perimeter_Aera;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wait_cnt_q <= 8'd0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Sampling on the LATENCY-th WAIT edge puts the sample LATENCY+1 edges after capture.
          if (wait_cnt_q == WAIT_LAST) begin
            sample_q <= cls_sdata;
            state_q  <= ST_CHECK;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ST_CHECK: begin
`ifdef GESTURE_CTRL_DEBOUNCE_EN
          stable_cnt_q <= stable_cnt_d;
          last_code_q  <= sample_q;
`endif
          if (report_s) begin
            out_code_q  <= sample_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (out_valid_q && out_ready) begin
`ifdef GESTURE_CTRL_DEBOUNCE_EN
            last_rep_q <= out_code_q;
`endif
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cls_hu_1  = cls_hu_1_q;
  assign cls_hu_2  = cls_hu_2_q;
  assign cls_pa    = cls_pa_q;
  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
